aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Sequencer for the AES-128 key-expansion datapath. It accepts a 128-bit cipher key over a valid/ready handshake and drives the expansion datapath's mode code, round counter and key words. It streams round keys 0..10 to the cipher core over a valid/ready port, stalling the datapath under backpressure. An optional round-key cache allows reverse-order replay for decryption without re-expanding the key.

## Interface
Parameters:
- `NR`, 10: number of rounds; the last round-key index.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `key_valid_i`  in  1: a new cipher key is offered.
- `key_ready_o`  out  1: controller accepts a key; high only in IDLE.
- `key_i`  in  128: cipher key; `[127:96]` is word 0.
- `flush_i`  in  1: synchronous abort; returns to IDLE.
- `replay_req_i`  in  1: start a reverse-order stream from the cache. Cache build only.
- `ke_mode_o`  out  3: datapath mode: `000` hold, `001` load, `010` expand.
- `ke_count_o`  out  4: datapath round counter.
- `ke_key_o`  out  128: words 0..3 driven to the datapath key inputs.
- `ke_rk_i`  in  128: datapath round-key output, words 0..3 concatenated.
- `rk_valid_o`  out  1: round key is valid.
- `rk_ready_i`  in  1: consumer accepts the round key.
- `rk_data_o`  out  128: round key.
- `rk_idx_o`  out  4: round-key index, 0..10.
- `rk_last_o`  out  1: final key of the current stream.
- `busy_o`  out  1: state is not IDLE.
- `done_o`  out  1: one-cycle pulse after the final handshake.
- `cache_valid_o`  out  1: all 11 round keys are stored in the cache.

## Operation
- **IDLE.** `key_ready_o`=1 and `ke_mode_o`=000.
  - On `key_valid_i`: latch `key_i` into `key_r`, then go to LOAD.
  - Else, if `replay_req_i` and `cache_valid_o`: go to REPLAY with `idx`=NR.
  - A key request has priority over a replay request.
- **LOAD** (1 cycle). `ke_mode_o`=001, `ke_count_o`=0, `ke_key_o`=`key_r`. Next state is EXPAND with count 0.
- **EXPAND.**
  - `rk_valid_o`=1, `rk_data_o`=`ke_rk_i`, `rk_idx_o`=count, `rk_last_o`=(count==NR).
  - `ke_mode_o`=010 when `rk_ready_i`=1, else 000. Driving 000 freezes the datapath registers, so `ke_rk_i` stays stable during a stall.
  - On a handshake with count<NR: count increments.
  - On a handshake with count==NR: go to IDLE and pulse `done_o`.
- **REPLAY** (cache build only). Streams stored keys from index NR down to 0.
  - `rk_last_o`=(idx==0).
  - `ke_mode_o`=000 throughout.
  - The handshake at idx 0 returns to IDLE and pulses `done_o`.
- **flush_i.** Overrides everything. The next state is IDLE, and a handshake in the same cycle is discarded (no `done_o`, no cache write). The cache is invalidated.
- **Output defaults.**
  - `ke_key_o` holds `key_r` in every state.
  - `ke_count_o` holds its last value outside EXPAND.
  - `rk_*` outputs are 0 when `rk_valid_o`=0.
  - `rk_valid_o` must not drop once asserted until the handshake, except on flush.
- **Counter width.** `count` is 4 bits and never exceeds NR; there is no wrap.

## Timing
- **Reset values.**
  - State IDLE, so `key_ready_o`=1.
  - All other outputs are 0, including `ke_mode_o`=000.
  - `key_r`=0 and `cache_valid_o`=0.
- **Latency.**
  - Key accepted at edge T: LOAD in cycle T+1, first `rk_valid_o` in cycle T+2.
  - With no backpressure, the 11 keys appear on 11 consecutive cycles.
  - `key_ready_o` rises the cycle after the final handshake.
- **Combinational path.** `rk_data_o` is combinational from `ke_rk_i`, which passes through the S-box. The consumer must register it.
- **Reset mid-stream.** Immediately returns to IDLE and clears the cache.

## Configuration
- **`AES_KE_RK_CACHE_EN` defined.**
  - Each EXPAND handshake writes `ke_rk_i` into `cache[count]`.
  - `cache_valid_o` sets on the handshake at idx NR.
  - `cache_valid_o` clears on key accept, flush, or reset.
  - REPLAY is available.
- **Macro undefined.**
  - No storage and no REPLAY state.
  - `replay_req_i` is ignored and `cache_valid_o` is tied to 0.

## Structure
- **Package `aes_pkg`** holds:
  - state enum {IDLE, LOAD, EXPAND, REPLAY};
  - `KE_MODE_HOLD`=3'b000, `KE_MODE_LOAD`=3'b001, `KE_MODE_EXPAND`=3'b010;
  - `AES_NR`=10.
- **Sub-module `aes_rk_cache`:** 11×128 register file with one synchronous write port, one asynchronous read port, and a valid flag. It is instantiated only under `AES_KE_RK_CACHE_EN`.

## Test plan
- **Nominal stream.** Key `2b7e1516 28aed2a6 abf71588 09cf4f3c` with `rk_ready_i`=1.
  - idx 0 equals the key; idx 1 = `a0fafe17 88542cb1 23a33939 2a6c7605`.
  - idx 10 = `d014f9a8 c9ee2589 e13f0cc8 b6630ca6`, with `rk_last_o`=1.
  - `done_o` pulses once; total of 13 cycles from key accept to IDLE.
- **Backpressure.** Same key with `rk_ready_i` toggling 1,0,0,1…
  - The same 11 keys appear in order, each held stable while stalled.
  - `ke_mode_o`=000 in every stall cycle.
- **Flush.** `flush_i` during idx 5 (same cycle as `rk_ready_i`=1).
  - IDLE next cycle with no `done_o`.
  - A new key then restarts at idx 0.
- **Reset.** Assert `rst_n`=0 during EXPAND: all outputs go to reset values, and `key_ready_o`=1 after release.
- **Replay (macro on).** After the nominal stream, pulse `replay_req_i`.
  - idx 10..0 appear in reverse order: the first is `d014f9a8…`, the last is the key, with `rk_last_o` at idx 0.
  - `ke_mode_o` stays at 000.
- **Priority (macro on).** `key_valid_i` and `replay_req_i` asserted together in IDLE.
  - The new key is accepted (LOAD).
  - `cache_valid_o` drops the next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule controller.
// Contents: controller state enum, datapath mode codes, round count, bus widths.
package aes_pkg;

    localparam int unsigned AES_NR = 10;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MODE_W = 3;

    typedef logic [BLK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        REPLAY = 2'd3
    } ks_state_e;

    localparam logic [MODE_W-1:0] KE_MODE_HOLD   = 3'b000;
    localparam logic [MODE_W-1:0] KE_MODE_LOAD   = 3'b001;
    localparam logic [MODE_W-1:0] KE_MODE_EXPAND = 3'b010;

endpackage

// File: rtl/aes_rk_cache.sv
// Round-key cache: DEPTH x 128-bit register file, one synchronous write port,
// one asynchronous read port, and a valid flag (clear has priority over set).
// Ports: clk, rst_n; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read
// port; set_valid/clr_valid flag controls; valid flag output.
module aes_rk_cache
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = AES_NR + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_addr,
    input  aes_block_t       wr_data,
    input  logic [CNT_W-1:0] rd_addr,
    output aes_block_t       rd_data,
    input  logic             set_valid,
    input  logic             clr_valid,
    output logic             valid
);

    aes_block_t mem [DEPTH];

    // Storage is cleared on reset so a stale key never survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clr_valid) begin
            valid <= 1'b0;
        end else if (set_valid) begin
            valid <= 1'b1;
        end
    end

    assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer. Accepts a cipher key, steps the external
// expansion datapath (mode/count/key), and streams round keys 0..NR to the
// cipher core over a valid/ready port, freezing the datapath on backpressure.
// Optional build macro AES_KE_RK_CACHE_EN adds a round-key cache and a REPLAY
// state that streams keys NR..0 without re-expanding.
// Ports: key_valid_i/key_ready_o/key_i key intake; flush_i abort;
// replay_req_i replay start; ke_mode_o/ke_count_o/ke_key_o/ke_rk_i datapath;
// rk_valid_o/rk_ready_i/rk_data_o/rk_idx_o/rk_last_o round-key stream;
// busy_o, done_o, cache_valid_o status.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    input  logic [BLK_W-1:0]  key_i,
    input  logic              flush_i,
    input  logic              replay_req_i,
    output logic [MODE_W-1:0] ke_mode_o,
    output logic [CNT_W-1:0]  ke_count_o,
    output logic [BLK_W-1:0]  ke_key_o,
    input  logic [BLK_W-1:0]  ke_rk_i,
    output logic              rk_valid_o,
    input  logic              rk_ready_i,
    output logic [BLK_W-1:0]  rk_data_o,
    output logic [CNT_W-1:0]  rk_idx_o,
    output logic              rk_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cache_valid_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NR);

    ks_state_e        state, state_nxt;
    aes_block_t       key_r, key_r_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             done_r, done_nxt;
    logic             cache_wr_c, cache_set_c, cache_clr_c;

`ifdef AES_KE_RK_CACHE_EN
    logic [CNT_W-1:0] idx, idx_nxt;
    aes_block_t       cache_rd_c;
    logic             cache_valid_c;
`endif

    // State and datapath-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            key_r  <= '0;
            count  <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            key_r  <= key_r_nxt;
            count  <= count_nxt;
            done_r <= done_nxt;
        end
    end

`ifdef AES_KE_RK_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end
`endif

    // Next-state and stream/datapath outputs.
    always_comb begin
        state_nxt   = state;
        key_r_nxt   = key_r;
        count_nxt   = count;
        done_nxt    = 1'b0;
        cache_wr_c  = 1'b0;
        cache_set_c = 1'b0;
        cache_clr_c = 1'b0;
        key_ready_o = 1'b0;
        ke_mode_o   = KE_MODE_HOLD;
        rk_valid_o  = 1'b0;
        rk_data_o   = '0;
        rk_idx_o    = '0;
        rk_last_o   = 1'b0;
`ifdef AES_KE_RK_CACHE_EN
        idx_nxt     = idx;
`endif

        case (state)
            IDLE: begin
                key_ready_o = 1'b1;
                if (key_valid_i) begin
                    key_r_nxt   = key_i;
                    count_nxt   = '0;
                    cache_clr_c = 1'b1;
                    state_nxt   = LOAD;
                end
`ifdef AES_KE_RK_CACHE_EN
                else if (replay_req_i && cache_valid_c) begin
                    idx_nxt   = LAST_IDX;
                    state_nxt = REPLAY;
                end
`endif
            end

            LOAD: begin
                ke_mode_o = KE_MODE_LOAD;
                state_nxt = EXPAND;
            end

            // Datapath advances only on a handshake, so ke_rk_i is frozen in a stall.
            EXPAND: begin
                rk_valid_o = 1'b1;
                rk_data_o  = ke_rk_i;
                rk_idx_o   = count;
                rk_last_o  = (count == LAST_IDX);
                ke_mode_o  = rk_ready_i ? KE_MODE_EXPAND : KE_MODE_HOLD;
                if (rk_ready_i) begin
                    cache_wr_c = 1'b1;
                    if (count == LAST_IDX) begin
                        cache_set_c = 1'b1;
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end

`ifdef AES_KE_RK_CACHE_EN
            REPLAY: begin
                rk_valid_o = 1'b1;
                rk_data_o  = cache_rd_c;
                rk_idx_o   = idx;
                rk_last_o  = (idx == '0);
                if (rk_ready_i) begin
                    if (idx == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx - 1'b1;
                    end
                end
            end
`endif

            default: state_nxt = IDLE;
        endcase

        // Abort discards any same-cycle handshake or key accept.
        if (flush_i) begin
            state_nxt   = IDLE;
            key_r_nxt   = key_r;
            count_nxt   = count;
            done_nxt    = 1'b0;
            cache_wr_c  = 1'b0;
            cache_set_c = 1'b0;
            cache_clr_c = 1'b1;
        end
    end

    assign ke_count_o = count;
    assign ke_key_o   = key_r;
    assign busy_o     = (state != IDLE);
    assign done_o     = done_r;

`ifdef AES_KE_RK_CACHE_EN
    aes_rk_cache #(
        .DEPTH (NR + 1)
    ) u_rk_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (cache_wr_c),
        .wr_addr   (count),
        .wr_data   (ke_rk_i),
        .rd_addr   (idx),
        .rd_data   (cache_rd_c),
        .set_valid (cache_set_c),
        .clr_valid (cache_clr_c),
        .valid     (cache_valid_c)
    );

    assign cache_valid_o = cache_valid_c;
`else
    logic unused_cache;
    assign unused_cache  = ^{replay_req_i, cache_wr_c, cache_set_c, cache_clr_c};
    assign cache_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with a behavioural AES-128
// expansion datapath and a word-array reference key schedule.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         key_valid, key_ready, flush, replay_req;
    logic [127:0] key, ke_key, ke_rk, rk_data;
    logic [2:0]   ke_mode;
    logic [3:0]   ke_count, rk_idx;
    logic         rk_valid, rk_ready, rk_last, busy, done, cache_valid;

    int total;
    int bad;
    int stream_cycles;

    logic [127:0] exp_rk [11];
    logic [127:0] got    [11];
    logic [127:0] dp_rk;

    typedef struct {
        int           idx;
        logic [127:0] rk;
    } kv_t;

    typedef struct {
        logic [127:0] key;
        int           pat;
    } scen_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid_i   (key_valid),
        .key_ready_o   (key_ready),
        .key_i         (key),
        .flush_i       (flush),
        .replay_req_i  (replay_req),
        .ke_mode_o     (ke_mode),
        .ke_count_o    (ke_count),
        .ke_key_o      (ke_key),
        .ke_rk_i       (ke_rk),
        .rk_valid_o    (rk_valid),
        .rk_ready_i    (rk_ready),
        .rk_data_o     (rk_data),
        .rk_idx_o      (rk_idx),
        .rk_last_o     (rk_last),
        .busy_o        (busy),
        .done_o        (done),
        .cache_valid_o (cache_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, b, e;
        r = 8'h01; b = a; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < n; i++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // Behavioural expansion datapath: register updated by mode code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_rk <= '0;
        end else if (ke_mode == 3'b001) begin
            dp_rk <= ke_key;
        end else if (ke_mode == 3'b010) begin
            logic [31:0] t, n0, n1, n2, n3;
            t  = subrot(dp_rk[31:0]) ^ {rcon_of(int'(ke_count) + 1), 24'h0};
            n0 = dp_rk[127:96] ^ t;
            n1 = dp_rk[95:64] ^ n0;
            n2 = dp_rk[63:32] ^ n1;
            n3 = dp_rk[31:0] ^ n2;
            dp_rk <= {n0, n1, n2, n3};
        end
    end
    assign ke_rk = dp_rk;

    // Reference schedule as the standard 44-word expansion.
    task automatic build_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subrot(t) ^ {rcon_of(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_key(input logic [127:0] k);
        @(negedge clk);
        key = k; key_valid = 1'b1;
        #1;
        chk("key_ready_idle", 128'(key_ready), 128'(1));
        @(negedge clk);
        key_valid = 1'b0; key = '0;
        #1;
        chk("load_mode", 128'(ke_mode), 128'(3'b001));
        chk("load_count", 128'(ke_count), 128'(0));
        chk("load_key", ke_key, k);
        chk("load_busy", 128'(busy), 128'(1));
        chk("load_no_valid", 128'(rk_valid), 128'(0));
        build_ref(k);
    endtask

    // pat 0: always ready, 1: ready on every third cycle, 2: random ready.
    task automatic run_stream(input int pat, input bit rev);
        int          n, cyc, exp_i;
        bit          pend;
        logic [127:0] held;
        logic [3:0]  held_idx;
        n = 0; pend = 1'b0; held = '0; held_idx = '0;
        for (cyc = 0; cyc < 300 && n < 11; cyc++) begin
            @(negedge clk);
            case (pat)
                0:       rk_ready = 1'b1;
                1:       rk_ready = (cyc % 3 == 0);
                default: rk_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            exp_i = rev ? 10 - n : n;
            if (pend) begin
                chk("valid_held", 128'(rk_valid), 128'(1));
                chk("stall_data", rk_data, held);
                chk("stall_idx", 128'(rk_idx), 128'(held_idx));
            end
            if (rk_valid) begin
                if (!rev && rk_ready) chk("mode_expand", 128'(ke_mode), 128'(3'b010));
                else                  chk("mode_hold", 128'(ke_mode), 128'(3'b000));
                if (rk_ready) begin
                    chk("rk_idx", 128'(rk_idx), 128'(exp_i));
                    chk("rk_data", rk_data, exp_rk[exp_i]);
                    chk("rk_last", 128'(rk_last), 128'(exp_i == (rev ? 0 : 10)));
                    got[n] = rk_data;
                    n++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1; held = rk_data; held_idx = rk_idx;
                end
            end else begin
                chk("rk_data_zero", rk_data, '0);
            end
        end
        stream_cycles = cyc;
        if (n < 11) chk("stream_timeout", 128'(n), 128'(11));
        @(negedge clk);
        rk_ready = 1'b0;
        #1;
        chk("done_pulse", 128'(done), 128'(1));
        chk("ready_after", 128'(key_ready), 128'(1));
        chk("idle_not_busy", 128'(busy), 128'(0));
        chk("idle_no_valid", 128'(rk_valid), 128'(0));
        @(negedge clk);
        #1;
        chk("done_single", 128'(done), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        chk({tag, "_mode"}, 128'(ke_mode), 128'(0));
        chk({tag, "_count"}, 128'(ke_count), 128'(0));
        chk({tag, "_ke_key"}, ke_key, '0);
        chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, "_rk_data"}, rk_data, '0);
        chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
        chk({tag, "_rk_last"}, 128'(rk_last), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_cache_valid"}, 128'(cache_valid), 128'(0));
    endtask

    initial begin
        kv_t   kv   [3];
        scen_t scen [4];
        bit    found;

        total = 0; bad = 0; stream_cycles = 0;
        rst_n = 1'b0; key_valid = 1'b0; key = '0; flush = 1'b0;
        replay_req = 1'b0; rk_ready = 1'b0;

        kv[0] = '{0,  FIPS_KEY};
        kv[1] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        kv[2] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        scen[0] = '{{$urandom(), $urandom(), $urandom(), $urandom()}, 2};
        scen[1] = '{{$urandom(), $urandom(), $urandom(), $urandom()}, 2};
        scen[2] = '{128'hffffffffffffffffffffffffffffffff, 1};
        scen[3] = '{128'h0, 0};

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 128'(key_ready), 128'(1));

        // Nominal stream with the FIPS-197 key.
        send_key(FIPS_KEY);
        run_stream(0, 1'b0);
        chk("nominal_cycles", 128'(stream_cycles), 128'(11));
        for (int i = 0; i < 3; i++) chk("known_vector", got[kv[i].idx], kv[i].rk);
        chk("count_hold", 128'(ke_count), 128'(10));
        chk("ke_key_hold", ke_key, FIPS_KEY);

`ifdef AES_KE_RK_CACHE_EN
        chk("cache_valid_set", 128'(cache_valid), 128'(1));
        @(negedge clk);
        replay_req = 1'b1;
        @(negedge clk);
        replay_req = 1'b0;
        #1;
        chk("replay_busy", 128'(busy), 128'(1));
        run_stream(1, 1'b1);
        chk("replay_first", got[0], kv[2].rk);
        chk("replay_last", got[10], FIPS_KEY);
        chk("cache_kept", 128'(cache_valid), 128'(1));

        // Key request wins over a simultaneous replay request.
        @(negedge clk);
        key = scen[0].key; key_valid = 1'b1; replay_req = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; replay_req = 1'b0; key = '0;
        #1;
        chk("prio_load", 128'(ke_mode), 128'(3'b001));
        chk("prio_cache_clr", 128'(cache_valid), 128'(0));
        build_ref(scen[0].key);
        run_stream(0, 1'b0);
`else
        chk("cache_tied_off", 128'(cache_valid), 128'(0));
        @(negedge clk);
        replay_req = 1'b1;
        @(negedge clk);
        replay_req = 1'b0;
        #1;
        chk("replay_ignored", 128'(busy), 128'(0));
        chk("replay_no_valid", 128'(rk_valid), 128'(0));
`endif

        // Backpressure 1,0,0 pattern with the FIPS key.
        send_key(FIPS_KEY);
        run_stream(1, 1'b0);
        for (int i = 0; i < 3; i++) chk("bp_known_vector", got[kv[i].idx], kv[i].rk);

        // Scenario table: keys and ready patterns.
        for (int s = 0; s < 4; s++) begin
            send_key(scen[s].key);
            run_stream(scen[s].pat, 1'b0);
        end

        // Flush during idx 5 with a same-cycle handshake.
        send_key(FIPS_KEY);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            rk_ready = 1'b1;
            #1;
            if (rk_valid && rk_idx == 4'd5) found = 1'b1;
        end
        chk("flush_reach_idx5", 128'(found), 128'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; rk_ready = 1'b0;
        #1;
        chk("flush_idle", 128'(busy), 128'(0));
        chk("flush_no_done", 128'(done), 128'(0));
        chk("flush_no_valid", 128'(rk_valid), 128'(0));
        chk("flush_ready", 128'(key_ready), 128'(1));
        chk("flush_cache_clr", 128'(cache_valid), 128'(0));
        @(negedge clk);
        #1;
        chk("flush_no_done_late", 128'(done), 128'(0));
        send_key(scen[1].key);
        run_stream(0, 1'b0);

        // Reset in the middle of EXPAND.
        send_key(FIPS_KEY);
        repeat (3) begin
            @(negedge clk);
            rk_ready = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1; rk_ready = 1'b0;
        #1;
        chk("midrst_release_ready", 128'(key_ready), 128'(1));
        chk("midrst_release_busy", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
